// File: rtl/uart_tx_gen2.sv
// UART transmitter: start, DATA_WIDTH data bits LSB first, optional parity, one or two stop bits.
// Define UART_TX_HOLD_EN to add a one-word holding register for gap-free back-to-back frames.
module uart_tx_gen2 #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    output logic                  DATA_READY,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    output logic                  BUSY,
    output logic                  TX_OUT
);

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

    localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

    state_t                  state_q, state_d;
    logic [PRESCALE_W-1:0]   cnt_q, cnt_d, pre_q, pre_d;
    logic [DATA_WIDTH-1:0]   sh_q, sh_d;
    logic [3:0]              bit_q, bit_d;
    logic                    stop_q, stop_d;
    logic                    par_en_q, par_en_d, par_bit_q, par_bit_d, stop2_q, stop2_d;
    logic                    tx_q, tx_d, busy_q, busy_d, ready_q, ready_d;

    logic                    accept, bit_done, frame_end, load_in, load_hold, load;
    logic [DATA_WIDTH-1:0]   src_data;
    logic [PRESCALE_W-1:0]   src_pre;
    logic                    src_par_en, src_par_bit, src_stop2, in_par_bit;

    always_comb begin
        accept     = DATA_VALID & ready_q;
        bit_done   = (cnt_q == '0);
        frame_end  = (state_q == ST_STOP) && bit_done && (stop_q == stop2_q);
        in_par_bit = (^P_DATA) ^ PAR_TYP;
    end

`ifdef UART_TX_HOLD_EN
    logic                  hold_valid_q, hold_valid_d;
    logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic [PRESCALE_W-1:0] hold_pre_q, hold_pre_d;
    logic                  hold_par_en_q, hold_par_en_d, hold_par_bit_q, hold_par_bit_d;
    logic                  hold_stop2_q, hold_stop2_d;

    // A word offered on the last stop edge goes straight to the shifter; otherwise it waits in the hold slot.
    always_comb begin
        load_hold      = frame_end & hold_valid_q;
        load_in        = accept & ((state_q == ST_IDLE) | frame_end);
        hold_valid_d   = hold_valid_q;
        hold_data_d    = hold_data_q;
        hold_pre_d     = hold_pre_q;
        hold_par_en_d  = hold_par_en_q;
        hold_par_bit_d = hold_par_bit_q;
        hold_stop2_d   = hold_stop2_q;
        if (accept && !load_in) begin
            hold_valid_d   = 1'b1;
            hold_data_d    = P_DATA;
            hold_pre_d     = PRESCALE;
            hold_par_en_d  = PAR_EN;
            hold_par_bit_d = in_par_bit;
            hold_stop2_d   = STOP2;
        end else if (load_hold) begin
            hold_valid_d = 1'b0;
        end
        src_data    = load_hold ? hold_data_q    : P_DATA;
        src_pre     = load_hold ? hold_pre_q     : PRESCALE;
        src_par_en  = load_hold ? hold_par_en_q  : PAR_EN;
        src_par_bit = load_hold ? hold_par_bit_q : in_par_bit;
        src_stop2   = load_hold ? hold_stop2_q   : STOP2;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            hold_valid_q   <= 1'b0;
            hold_data_q    <= '0;
            hold_pre_q     <= '0;
            hold_par_en_q  <= 1'b0;
            hold_par_bit_q <= 1'b0;
            hold_stop2_q   <= 1'b0;
        end else begin
            hold_valid_q   <= hold_valid_d;
            hold_data_q    <= hold_data_d;
            hold_pre_q     <= hold_pre_d;
            hold_par_en_q  <= hold_par_en_d;
            hold_par_bit_q <= hold_par_bit_d;
            hold_stop2_q   <= hold_stop2_d;
        end
    end
`else
    always_comb begin
        load_hold   = 1'b0;
        load_in     = accept;
        src_data    = P_DATA;
        src_pre     = PRESCALE;
        src_par_en  = PAR_EN;
        src_par_bit = in_par_bit;
        src_stop2   = STOP2;
    end
`endif

    assign load = load_in | load_hold;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (load_in) state_d = ST_START;
            ST_START:  if (bit_done) state_d = ST_DATA;
            ST_DATA:   if (bit_done && bit_q == LAST_BIT) state_d = par_en_q ? ST_PARITY : ST_STOP;
            ST_PARITY: if (bit_done) state_d = ST_STOP;
            ST_STOP:   if (frame_end) state_d = load ? ST_START : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        pre_d     = pre_q;
        sh_d      = sh_q;
        bit_d     = bit_q;
        stop_d    = stop_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        stop2_d   = stop2_q;
        if (load) begin
            cnt_d     = src_pre;
            pre_d     = src_pre;
            sh_d      = src_data;
            bit_d     = '0;
            stop_d    = 1'b0;
            par_en_d  = src_par_en;
            par_bit_d = src_par_bit;
            stop2_d   = src_stop2;
        end else if (state_q != ST_IDLE) begin
            if (bit_done) begin
                cnt_d = pre_q;
                if (state_q == ST_DATA) begin
                    sh_d  = sh_q >> 1;
                    bit_d = bit_q + 4'd1;
                end
                if (state_q == ST_STOP) stop_d = 1'b1;
            end else begin
                cnt_d = cnt_q - PRESCALE_W'(1);
            end
        end
    end

    always_comb begin
        unique case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = sh_d[0];
            ST_PARITY: tx_d = par_bit_d;
            default:   tx_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
`ifdef UART_TX_HOLD_EN
        ready_d = ~hold_valid_d;
`else
        ready_d = (state_d == ST_IDLE);
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pre_q     <= '0;
            sh_q      <= '0;
            bit_q     <= '0;
            stop_q    <= 1'b0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pre_q     <= pre_d;
            sh_q      <= sh_d;
            bit_q     <= bit_d;
            stop_q    <= stop_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            stop2_q   <= stop2_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
        end
    end

    assign TX_OUT     = tx_q;
    assign BUSY       = busy_q;
    assign DATA_READY = ready_q;

endmodule

// File: tb/tb_uart_tx_gen2.sv
// Scoreboard bench for uart_tx_gen2: expected frames queued at acceptance, checked cycle by cycle on TX_OUT.
module tb_uart_tx_gen2;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  P_DATA;
    logic        DATA_VALID, DATA_READY, PAR_EN, PAR_TYP, STOP2, BUSY, TX_OUT;
    logic [15:0] PRESCALE;

    logic [4:0]  d5_data;
    logic        d5_valid, d5_ready, d5_par_en, d5_par_typ, d5_stop2, d5_busy, d5_tx;
    logic [15:0] d5_pre;

    always #5 CLK = ~CLK;

    uart_tx_gen2 #(.DATA_WIDTH(8), .PRESCALE_W(16)) dut (
        .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID), .DATA_READY(DATA_READY),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2), .PRESCALE(PRESCALE),
        .BUSY(BUSY), .TX_OUT(TX_OUT)
    );

    uart_tx_gen2 #(.DATA_WIDTH(5), .PRESCALE_W(16)) dut5 (
        .CLK(CLK), .RST(RST), .P_DATA(d5_data), .DATA_VALID(d5_valid), .DATA_READY(d5_ready),
        .PAR_EN(d5_par_en), .PAR_TYP(d5_par_typ), .STOP2(d5_stop2), .PRESCALE(d5_pre),
        .BUSY(d5_busy), .TX_OUT(d5_tx)
    );

    typedef struct {
        logic [12:0] bits;
        int unsigned nbits;
        int unsigned pre;
        int unsigned start;
    } frame_t;

    int          tests_run = 0;
    int          tests_failed = 0;
    int unsigned cyc = 0;
    frame_t      exp_q[$];
    int unsigned start_log[$];
    int          frames_done = 0;
    int          exp_frames = 0;
    int          stray = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog");
    end

    function automatic frame_t build_frame(input logic [8:0] d, input int unsigned dw, input logic pe,
                                           input logic pt, input logic s2, input int unsigned pre,
                                           input int unsigned start);
        frame_t      f;
        logic [12:0] v;
        logic [3:0]  n;
        logic [8:0]  dd;
        logic        p;
        v  = '1;
        v[0] = 1'b0;
        n  = 4'd1;
        dd = d;
        p  = pt;
        for (int unsigned i = 0; i < dw; i++) begin
            v[n] = dd[0];
            p    = p ^ dd[0];
            dd   = dd >> 1;
            n    = n + 4'd1;
        end
        if (pe) begin
            v[n] = p;
            n    = n + 4'd1;
        end
        n = n + 4'd1;
        if (s2) n = n + 4'd1;
        f.bits  = v;
        f.nbits = 32'(n);
        f.pre   = pre;
        f.start = start;
        return f;
    endfunction

    task automatic monitor();
        frame_t      f;
        int          bad_tx, bad_busy;
        bit          just_ended, follow;
        logic [12:0] sh;
        just_ended = 1'b0;
        forever begin
            @(negedge CLK);
            if (just_ended) begin
                just_ended = 1'b0;
                follow = (TX_OUT === 1'b0) && (exp_q.size() > 0);
`ifndef UART_TX_HOLD_EN
                follow = 1'b0;
`endif
                if (!follow) begin
                    tests_run++;
                    if (BUSY !== 1'b0 || TX_OUT !== 1'b1) begin
                        tests_failed++;
                        $display("FAIL frame_end_idle: BUSY=%b TX_OUT=%b, required BUSY=0 TX_OUT=1", BUSY, TX_OUT);
                    end
                end
            end
            if (RST === 1'b0 && TX_OUT === 1'b0) begin
                if (exp_q.size() == 0) begin
                    stray++;
                end else begin
                    f = exp_q.pop_front();
                    start_log.push_back(cyc);
                    tests_run++;
                    if (cyc !== f.start) begin
                        tests_failed++;
                        $display("FAIL start_latency: start bit seen at cycle %0d, required %0d", cyc, f.start);
                    end
                    bad_tx = 0;
                    bad_busy = 0;
                    for (int unsigned c = 0; c < f.nbits * (f.pre + 1); c++) begin
                        if (c != 0) @(negedge CLK);
                        sh = f.bits >> (c / (f.pre + 1));
                        if (TX_OUT !== sh[0]) bad_tx++;
                        if (BUSY !== 1'b1) bad_busy++;
                    end
                    tests_run++;
                    if (bad_tx != 0) begin
                        tests_failed++;
                        $display("FAIL frame_bits: %0d wrong TX_OUT cycles, required 0 (frame %b, %0d bits)",
                                 bad_tx, f.bits, f.nbits);
                    end
                    tests_run++;
                    if (bad_busy != 0) begin
                        tests_failed++;
                        $display("FAIL frame_busy: %0d cycles with BUSY low, required 0", bad_busy);
                    end
                    frames_done++;
                    just_ended = 1'b1;
                end
            end
        end
    endtask

    task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic s2,
                        input logic [15:0] pre, input bit push);
        bit ok;
        ok = 1'b0;
        @(negedge CLK);
        P_DATA = d; PAR_EN = pe; PAR_TYP = pt; STOP2 = s2; PRESCALE = pre; DATA_VALID = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (DATA_READY === 1'b1) begin
                @(posedge CLK);
                #1;
                ok = 1'b1;
            end else begin
                @(negedge CLK);
            end
        end
        DATA_VALID = 1'b0;
        if (ok) begin
            if (push) begin
                exp_q.push_back(build_frame({1'b0, d}, 8, pe, pt, s2, 32'(pre), cyc));
                exp_frames++;
            end
            // Disturb the inputs so a frame that fails to capture them at acceptance shows up.
            P_DATA = ~d; PAR_EN = ~pe; PAR_TYP = ~pt; STOP2 = ~s2; PRESCALE = pre ^ 16'h5;
        end else begin
            tests_run++;
            tests_failed++;
            $display("FAIL send_timeout: DATA_READY=%b, required 1 within 300 cycles", DATA_READY);
        end
    endtask

    task automatic wait_frames(input int target);
        int n;
        n = 0;
        while (frames_done < target && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        @(negedge CLK);
        tests_run++;
        if (frames_done < target) begin
            tests_failed++;
            $display("FAIL wait_frames: %0d frames seen, required %0d", frames_done, target);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        P_DATA = '0; DATA_VALID = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0; PRESCALE = '0;
        d5_data = '0; d5_valid = 1'b0; d5_par_en = 1'b0; d5_par_typ = 1'b0; d5_stop2 = 1'b0; d5_pre = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        tests_run++;
        if (TX_OUT !== 1'b1 || BUSY !== 1'b0 || DATA_READY !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: TX_OUT=%b BUSY=%b DATA_READY=%b, required 1 0 0", TX_OUT, BUSY, DATA_READY);
        end
        tests_run++;
        if (d5_tx !== 1'b1 || d5_busy !== 1'b0 || d5_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state_w5: TX_OUT=%b BUSY=%b DATA_READY=%b, required 1 0 0", d5_tx, d5_busy, d5_ready);
        end
        RST = 1'b0;
        @(negedge CLK);
        tests_run++;
        if (DATA_READY !== 1'b1 || d5_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL ready_after_reset: DATA_READY=%b/%b, required 1/1", DATA_READY, d5_ready);
        end
    endtask

    task automatic test_basic();
        send(8'hA5, 1'b0, 1'b0, 1'b0, 16'd3, 1'b1);
        wait_frames(exp_frames);
    endtask

    task automatic test_parity();
        send(8'hA5, 1'b1, 1'b0, 1'b0, 16'd3, 1'b1);
        wait_frames(exp_frames);
        send(8'hA5, 1'b1, 1'b1, 1'b0, 16'd3, 1'b1);
        wait_frames(exp_frames);
        send(8'h3C, 1'b1, 1'b1, 1'b1, 16'd2, 1'b1);
        wait_frames(exp_frames);
    endtask

    task automatic test_stop2();
        send(8'h00, 1'b0, 1'b0, 1'b1, 16'd0, 1'b1);
        wait_frames(exp_frames);
        send(8'hFF, 1'b1, 1'b0, 1'b1, 16'd0, 1'b1);
        wait_frames(exp_frames);
    endtask

    task automatic test_back_to_back();
        int unsigned base, gap, want;
        base = start_log.size();
        send(8'h55, 1'b0, 1'b0, 1'b0, 16'd3, 1'b1);
        send(8'h0F, 1'b0, 1'b0, 1'b0, 16'd3, 1'b1);
        wait_frames(exp_frames);
`ifdef UART_TX_HOLD_EN
        want = 40;
`else
        want = 41;
`endif
        gap = (start_log.size() >= base + 2) ? start_log[base + 1] - start_log[base] : 0;
        tests_run++;
        if (gap !== want) begin
            tests_failed++;
            $display("FAIL back_to_back_gap: start-to-start %0d cycles, required %0d", gap, want);
        end
    endtask

    task automatic test_busy_ignore();
        stray = 0;
        send(8'hC3, 1'b1, 1'b0, 1'b0, 16'd3, 1'b1);
`ifdef UART_TX_HOLD_EN
        send(8'h3C, 1'b0, 1'b1, 1'b1, 16'd3, 1'b1);
`endif
        @(negedge CLK);
        tests_run++;
        if (DATA_READY !== 1'b0) begin
            tests_failed++;
            $display("FAIL ready_while_full: DATA_READY=%b, required 0", DATA_READY);
        end
        P_DATA = 8'hFF; PRESCALE = 16'd0; DATA_VALID = 1'b1;
        repeat (3) @(negedge CLK);
        DATA_VALID = 1'b0;
        wait_frames(exp_frames);
        repeat (20) @(negedge CLK);
        tests_run++;
        if (stray != 0 || BUSY !== 1'b0) begin
            tests_failed++;
            $display("FAIL ignored_offer: %0d stray start cycles, BUSY=%b, required 0 and 0", stray, BUSY);
        end
    endtask

    task automatic test_reset_midframe();
        int unsigned c0;
        int          n;
        send(8'hA5, 1'b0, 1'b0, 1'b0, 16'd3, 1'b0);
        c0 = cyc;
`ifdef UART_TX_HOLD_EN
        send(8'h81, 1'b0, 1'b0, 1'b0, 16'd3, 1'b0);
`endif
        n = 0;
        while (cyc < c0 + 17 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        tests_run++;
        if (TX_OUT !== 1'b0 || BUSY !== 1'b1) begin
            tests_failed++;
            $display("FAIL data_bit3: TX_OUT=%b BUSY=%b, required 0 1", TX_OUT, BUSY);
        end
        RST = 1'b1;
        @(negedge CLK);
        tests_run++;
        if (TX_OUT !== 1'b1 || BUSY !== 1'b0 || DATA_READY !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort: TX_OUT=%b BUSY=%b DATA_READY=%b, required 1 0 0", TX_OUT, BUSY, DATA_READY);
        end
        RST = 1'b0;
        @(negedge CLK);
        tests_run++;
        if (DATA_READY !== 1'b1) begin
            tests_failed++;
            $display("FAIL ready_after_abort: DATA_READY=%b, required 1", DATA_READY);
        end
        stray = 0;
        repeat (60) @(negedge CLK);
        tests_run++;
        if (stray != 0 || BUSY !== 1'b0) begin
            tests_failed++;
            $display("FAIL pending_discard: %0d stray start cycles, BUSY=%b, required 0 and 0", stray, BUSY);
        end
    endtask

    task automatic test_width5();
        frame_t      f;
        int          bad_tx, bad_busy;
        logic [12:0] sh;
        f = build_frame(9'h13, 5, 1'b1, 1'b0, 1'b0, 1, 0);
        @(negedge CLK);
        d5_data = 5'h13; d5_par_en = 1'b1; d5_par_typ = 1'b0; d5_stop2 = 1'b0; d5_pre = 16'd1; d5_valid = 1'b1;
        tests_run++;
        if (d5_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL w5_ready: DATA_READY=%b, required 1", d5_ready);
        end
        @(posedge CLK);
        #1;
        d5_valid = 1'b0; d5_data = 5'h0C; d5_pre = 16'd7; d5_par_typ = 1'b1; d5_stop2 = 1'b1;
        bad_tx = 0;
        bad_busy = 0;
        for (int unsigned c = 0; c < f.nbits * 2; c++) begin
            @(negedge CLK);
            sh = f.bits >> (c / 2);
            if (d5_tx !== sh[0]) bad_tx++;
            if (d5_busy !== 1'b1) bad_busy++;
        end
        tests_run++;
        if (bad_tx != 0) begin
            tests_failed++;
            $display("FAIL w5_bits: %0d wrong TX_OUT cycles, required 0", bad_tx);
        end
        tests_run++;
        if (bad_busy != 0) begin
            tests_failed++;
            $display("FAIL w5_busy: %0d cycles with BUSY low, required 0", bad_busy);
        end
        @(negedge CLK);
        tests_run++;
        if (d5_busy !== 1'b0 || d5_tx !== 1'b1) begin
            tests_failed++;
            $display("FAIL w5_end: BUSY=%b TX_OUT=%b, required 0 1", d5_busy, d5_tx);
        end
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_basic();
        test_parity();
        test_stop2();
        test_back_to_back();
        test_busy_ignore();
        test_reset_midframe();
        test_width5();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_tx_gen2.md
UART_TX_GEN2 -- requirements
Module: uart_tx_gen2

Interface
REQ-001 Parameter DATA_WIDTH, default 8, data bits per frame; legal range 5..9.
REQ-002 Parameter PRESCALE_W, default 16, width of the PRESCALE input.
REQ-003 Port CLK  in  1  single clock; all logic on its rising edge.
REQ-004 Port RST  in  1  reset, synchronous, active-high.
REQ-005 Port P_DATA  in  DATA_WIDTH  parallel word to transmit.
REQ-006 Port DATA_VALID  in  1  word-offer strobe; a word is accepted on a rising edge where DATA_VALID=1 and DATA_READY=1.
REQ-007 Port DATA_READY  out  1  block can accept a word this cycle.
REQ-008 Port PAR_EN  in  1  1 = append parity bit.
REQ-009 Port PAR_TYP  in  1  0 = even parity, 1 = odd parity.
REQ-010 Port STOP2  in  1  0 = one stop bit, 1 = two stop bits.
REQ-011 Port PRESCALE  in  PRESCALE_W  bit time = PRESCALE+1 CLK cycles.
REQ-012 Port BUSY  out  1  frame in progress.
REQ-013 Port TX_OUT  out  1  serial line, registered, idle high.

Function
REQ-014 Frame order SHALL be: start (0), DATA_WIDTH data bits LSB first, parity (only if PAR_EN), stop bits (1), one or two per STOP2.
REQ-015 Parity SHALL be XOR of data bits for even, inverted XOR for odd.
REQ-016 P_DATA, PAR_EN, PAR_TYP, STOP2 and PRESCALE SHALL be captured at acceptance; later input changes do not affect the frame in flight.
REQ-017 FSM states: IDLE, START, DATA, PARITY, STOP; IDLE->START on accept, START->DATA, DATA->PARITY after bit DATA_WIDTH-1 when parity on, else ->STOP, PARITY->STOP, STOP->IDLE after the last stop bit (or ->START if a word is pending).
REQ-018 A down-counter SHALL time each bit for exactly PRESCALE+1 cycles; PRESCALE=0 gives one cycle per bit.
REQ-019 Latency: word accepted on edge N; TX_OUT=0 (start bit) and BUSY=1 from edge N+1.
REQ-020 BUSY SHALL fall on the edge ending the last stop bit unless a pending word begins at that same edge.
REQ-021 Frame length in cycles SHALL be (1 + DATA_WIDTH + PAR_EN + 1 + STOP2) x (PRESCALE+1).
REQ-022 TX_OUT SHALL be 1 whenever the state is IDLE.
REQ-023 DATA_VALID while DATA_READY=0 SHALL be ignored; no word is lost or duplicated.

Reset
REQ-024 While RST=1 at a rising edge: state IDLE, TX_OUT=1, BUSY=0, DATA_READY=0, counters and holding register cleared.
REQ-025 DATA_READY SHALL go to 1 on the first edge with RST=0.
REQ-026 RST asserted mid-frame SHALL abort the frame: TX_OUT=1 on the next edge, and any pending word is discarded.

Configuration
REQ-027 Macro UART_TX_HOLD_EN defined: a one-word holding register is present; DATA_READY=1 whenever it is empty, including during a frame; a held word starts its start bit on the edge after the previous last stop bit, with no idle cycle.
REQ-028 Macro UART_TX_HOLD_EN undefined: no holding register; DATA_READY=1 only in IDLE; at least one idle-high cycle separates frames.

Verification
REQ-029 DATA_WIDTH=8, PRESCALE=3, PAR_EN=0, STOP2=0, P_DATA=0xA5 -> TX_OUT 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; BUSY high for 40 cycles.
REQ-030 Same word, PAR_EN=1: PAR_TYP=0 -> parity bit 0; PAR_TYP=1 -> parity bit 1; BUSY high for 44 cycles.
REQ-031 STOP2=1, PAR_EN=0, PRESCALE=0, P_DATA=0x00 -> 11-cycle frame: 0, eight 0s, 1, 1.
REQ-032 UART_TX_HOLD_EN defined, 0x55 then 0x0F offered back-to-back -> second start bit immediately follows the first frame's stop bit; BUSY stays continuously high.
REQ-033 RST pulsed during data bit 3 -> TX_OUT=1 and BUSY=0 on the next edge; DATA_READY=1 one edge after RST falls.
REQ-034 DATA_WIDTH=5, PRESCALE=1, P_DATA=0x13, PAR_EN=1, PAR_TYP=0 -> TX_OUT 0,1,1,0,0,1,1,1, each bit held 2 cycles.
